program_loader: RTL

- Upstream stage of the program ROM/RAM that the CPU fetches 18-bit instructions from.
- Accepts a byte stream over a valid/ready handshake, packs bytes into 18-bit instruction words and writes them sequentially from address 0.
- Verifies a checksum, then releases the CPU via o_cpuRun.
- Holds the CPU stopped (o_cpuRun=0) for the whole load.

---
 rtl/program_loader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: packs 3-byte groups into 18-bit words,
// writes them from address 0, verifies a checksum, then releases the CPU.
//
// Ports:
//   i_clock, i_reset     clock and synchronous active-high reset
//   i_byte, i_valid      incoming stream byte and its valid flag
//   o_ready              byte accepted this cycle when i_valid && o_ready
//   i_reload             restarts a load from DONE or ERROR
//   o_progAddr           program memory write address
//   o_progData           program memory write data, bit 0 is the MSB
//   o_progWrite          one-cycle write strobe
//   o_cpuRun             CPU may execute (DONE)
//   o_error              load failed (ERROR)
//   o_busy               load in progress (not DONE, not ERROR)
module program_loader #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned INSTR_WIDTH = 18,
    parameter int unsigned MAX_WORDS   = 65535
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [7:0]              i_byte,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_reload,
    output logic [ADDR_WIDTH-1:0]   o_progAddr,
    output logic [0:INSTR_WIDTH-1]  o_progData,
    output logic                    o_progWrite,
    output logic                    o_cpuRun,
    output logic                    o_error,
    output logic                    o_busy
);

    typedef enum logic [2:0] {
        CNT_HI,
        CNT_LO,
        D0,
        D1,
        D2,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]            cnt_hi;
    logic [15:0]           count;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [7:0]            sum;
    logic [1:0]            b0;
    logic [7:0]            b1;

    logic        accept;
    logic [15:0] n_word;
    logic        last_word;
    logic        finished;

    assign accept    = i_valid && o_ready;
    assign n_word    = {cnt_hi, i_byte};
    // Compared in 32 bits so the index never wraps before the test.
    assign last_word = (32'(word_idx) + 32'd1) == 32'(count);
    assign finished  = (state == DONE) || (state == ERROR);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= CNT_HI;
        end else begin
            state <= state_next;
        end
    end

    // Status outputs decode the state register only, so o_ready never
    // depends on i_valid and o_cpuRun rises the cycle after the checksum.
    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_busy     = 1'b1;
        o_cpuRun   = 1'b0;
        o_error    = 1'b0;
        unique case (state)
            CNT_HI: begin
                o_ready = 1'b1;
                if (accept) state_next = CNT_LO;
            end
            CNT_LO: begin
                o_ready = 1'b1;
                if (accept) begin
                    if (32'(n_word) > MAX_WORDS) state_next = ERROR;
                    else if (n_word == 16'd0)    state_next = CHECK;
                    else                         state_next = D0;
                end
            end
            D0: begin
                o_ready = 1'b1;
                if (accept) state_next = D1;
            end
            D1: begin
                o_ready = 1'b1;
                if (accept) state_next = D2;
            end
            D2: begin
                o_ready = 1'b1;
                if (accept) state_next = last_word ? CHECK : D0;
            end
            CHECK: begin
                o_ready = 1'b1;
                if (accept) state_next = (i_byte == sum) ? DONE : ERROR;
            end
            DONE: begin
                o_busy   = 1'b0;
                o_cpuRun = 1'b1;
                if (i_reload) state_next = CNT_HI;
            end
            ERROR: begin
                o_busy  = 1'b0;
                o_error = 1'b1;
                if (i_reload) state_next = CNT_HI;
            end
            default: state_next = CNT_HI;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt_hi      <= '0;
            count       <= '0;
            word_idx    <= '0;
            sum         <= '0;
            b0          <= '0;
            b1          <= '0;
            o_progAddr  <= '0;
            o_progData  <= '0;
            o_progWrite <= 1'b0;
        end else begin
            o_progWrite <= 1'b0;
            if (accept) begin
                // Sum grows on the checksum byte too, but is dead by then.
                sum <= sum + i_byte;
                case (state)
                    CNT_HI: cnt_hi <= i_byte;
                    CNT_LO: count  <= n_word;
                    D0:     b0     <= i_byte[1:0];
                    D1:     b1     <= i_byte;
                    D2: begin
                        o_progData  <= INSTR_WIDTH'({b0, b1, i_byte});
                        o_progAddr  <= word_idx;
                        o_progWrite <= 1'b1;
                        word_idx    <= word_idx + ADDR_WIDTH'(1);
                    end
                    default: ;
                endcase
            end
            if (finished && i_reload) begin
                count      <= '0;
                word_idx   <= '0;
                sum        <= '0;
                o_progAddr <= '0;
            end
        end
    end

endmodule
